alu_issue_ctrl: RTL

- Initiator side of the 32-bit ALU function-select interface: accepts one decoded-ready MIPS instruction plus register operands, drives F_Sel/S/T into the combinational ALU, captures Y/C/V and returns a registered result with destination and trap flags.
- Sits between register-read and writeback in the multicycle datapath.
- Performs shamt-based shifts by iterating the ALU's 1-bit shift ops.

---
 rtl/alu_pkg.sv | 98 +++++++++
 rtl/alu_issue_decode.sv | 131 +++++++++++++
 rtl/alu_issue_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue controller.
// ALU function-select codes, MIPS opcode/funct fields, FSM state and decode types.
// Optional feature macro used by this slice: SHIFT_VAR_EN (variable shifts).
package alu_pkg;

    // ALU function-select codes driven on F_Sel
    localparam logic [5:0] FS_PASS_S  = 6'h00;
    localparam logic [5:0] FS_PASS_T  = 6'h01;
    localparam logic [5:0] FS_ADD     = 6'h02;
    localparam logic [5:0] FS_SUB     = 6'h03;
    localparam logic [5:0] FS_ADDU    = 6'h04;
    localparam logic [5:0] FS_SUBU    = 6'h05;
    localparam logic [5:0] FS_SLT     = 6'h06;
    localparam logic [5:0] FS_SLTU    = 6'h07;
    localparam logic [5:0] FS_AND     = 6'h08;
    localparam logic [5:0] FS_OR      = 6'h09;
    localparam logic [5:0] FS_XOR     = 6'h0A;
    localparam logic [5:0] FS_NOR     = 6'h0B;
    localparam logic [5:0] FS_SLL     = 6'h0C;
    localparam logic [5:0] FS_SRL     = 6'h0D;
    localparam logic [5:0] FS_SRA     = 6'h0E;
    localparam logic [5:0] FS_INC     = 6'h0F;
    localparam logic [5:0] FS_INC4    = 6'h10;
    localparam logic [5:0] FS_DEC     = 6'h11;
    localparam logic [5:0] FS_DEC4    = 6'h12;
    localparam logic [5:0] FS_ZEROS   = 6'h13;
    localparam logic [5:0] FS_ONES    = 6'h14;
    localparam logic [5:0] FS_SP_INIT = 6'h15;
    localparam logic [5:0] FS_ANDI    = 6'h16;
    localparam logic [5:0] FS_ORI     = 6'h17;
    localparam logic [5:0] FS_LUI     = 6'h18;
    localparam logic [5:0] FS_XORI    = 6'h19;
    localparam logic [5:0] FS_NOT_S   = 6'h1A;
    localparam logic [5:0] FS_CHS     = 6'h1B;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // How operand T is formed at issue
    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,  // T = rt_val
        IMM_SEXT = 2'd1,  // T = sign-extended imm16
        IMM_ZEXT = 2'd2   // T = zero-extended imm16
    } imm_mode_e;

    typedef struct packed {
        logic [5:0] fsel;
        imm_mode_e  imm_mode;
        logic       is_shift;
        logic       var_shift;  // shift amount comes from rs_val[4:0]
        logic [4:0] shamt;
        logic [4:0] dest;
        logic       illegal;
    } decode_t;

    // Ops whose C/V outputs the ALU actually defines; all others report 0
    function automatic logic flags_defined(input logic [5:0] fsel);
        return fsel inside {FS_ADD, FS_SUB, FS_ADDU, FS_SUBU, FS_SLL, FS_SRL, FS_SRA};
    endfunction

    // Signed ops whose overflow may trap (ADD, SUB, ADDI)
    function automatic logic ovf_can_trap(input logic [5:0] fsel);
        return fsel inside {FS_ADD, FS_SUB};
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational MIPS instruction -> ALU issue decode.
// With SHIFT_VAR_EN defined, SLLV/SRLV/SRAV decode as shifts whose amount
// comes from rs_val; otherwise those functs are illegal.
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output decode_t     dec
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt_idx;
    logic [4:0] rd_idx;
    logic [4:0] shamt;
    logic       unused_rs;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign rt_idx = instr[20:16];
    assign rd_idx = instr[15:11];
    assign shamt  = instr[10:6];
    // The rs index is resolved upstream; the operand arrives as rs_val
    assign unused_rs = ^instr[25:21];

    // Instruction decode; illegal encodings collapse to an all-zero decode
    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves one unassigned (no latch).
        dec          = '0;
        dec.fsel     = FS_PASS_S;
        dec.imm_mode = IMM_NONE;
        case (opcode)
            OP_RTYPE: begin
                dec.dest = rd_idx;
                case (funct)
                    FN_ADD:  dec.fsel = FS_ADD;
                    FN_ADDU: dec.fsel = FS_ADDU;
                    FN_SUB:  dec.fsel = FS_SUB;
                    FN_SUBU: dec.fsel = FS_SUBU;
                    FN_AND:  dec.fsel = FS_AND;
                    FN_OR:   dec.fsel = FS_OR;
                    FN_XOR:  dec.fsel = FS_XOR;
                    FN_NOR:  dec.fsel = FS_NOR;
                    FN_SLT:  dec.fsel = FS_SLT;
                    FN_SLTU: dec.fsel = FS_SLTU;
                    FN_SLL: begin
                        dec.fsel     = FS_SLL;
                        dec.is_shift = 1'b1;
                        dec.shamt    = shamt;
                    end
                    FN_SRL: begin
                        dec.fsel     = FS_SRL;
                        dec.is_shift = 1'b1;
                        dec.shamt    = shamt;
                    end
                    FN_SRA: begin
                        dec.fsel     = FS_SRA;
                        dec.is_shift = 1'b1;
                        dec.shamt    = shamt;
                    end
`ifdef SHIFT_VAR_EN
                    FN_SLLV: begin
                        dec.fsel      = FS_SLL;
                        dec.is_shift  = 1'b1;
                        dec.var_shift = 1'b1;
                    end
                    FN_SRLV: begin
                        dec.fsel      = FS_SRL;
                        dec.is_shift  = 1'b1;
                        dec.var_shift = 1'b1;
                    end
                    FN_SRAV: begin
                        dec.fsel      = FS_SRA;
                        dec.is_shift  = 1'b1;
                        dec.var_shift = 1'b1;
                    end
`else
                    // Variable shifts are not supported and fall to the illegal default
`endif
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                dec.fsel     = FS_ADD;
                dec.imm_mode = IMM_SEXT;
                dec.dest     = rt_idx;
            end
            OP_ADDIU: begin
                dec.fsel     = FS_ADDU;
                dec.imm_mode = IMM_SEXT;
                dec.dest     = rt_idx;
            end
            OP_SLTI: begin
                dec.fsel     = FS_SLT;
                dec.imm_mode = IMM_SEXT;
                dec.dest     = rt_idx;
            end
            OP_SLTIU: begin
                dec.fsel     = FS_SLTU;
                dec.imm_mode = IMM_SEXT;
                dec.dest     = rt_idx;
            end
            OP_ANDI: begin
                dec.fsel     = FS_ANDI;
                dec.imm_mode = IMM_ZEXT;
                dec.dest     = rt_idx;
            end
            OP_ORI: begin
                dec.fsel     = FS_ORI;
                dec.imm_mode = IMM_ZEXT;
                dec.dest     = rt_idx;
            end
            OP_XORI: begin
                dec.fsel     = FS_XORI;
                dec.imm_mode = IMM_ZEXT;
                dec.dest     = rt_idx;
            end
            OP_LUI: begin
                dec.fsel     = FS_LUI;
                dec.imm_mode = IMM_ZEXT;
                dec.dest     = rt_idx;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one decoded MIPS instruction to a combinational ALU,
// iterates 1-bit shift ops for shamt shifts, and holds a registered result
// with destination and trap flags until the consumer takes it.
// Optional feature macro: SHIFT_VAR_EN (SLLV/SRLV/SRAV support in the decoder).
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned TRAP_ON_OVF = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [5:0]  F_Sel,
    output logic [31:0] S,
    output logic [31:0] T,
    input  logic [31:0] Y,
    input  logic        C,
    input  logic        V,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        c_flag,
    output logic        v_flag,
    output logic [4:0]  dest,
    output logic        ovf_trap,
    output logic        illegal
);

    state_e      state_q, state_d;
    logic        armed_q;
    logic [5:0]  fsel_q, fsel_d;
    logic [31:0] s_q, s_d;
    logic [31:0] t_q, t_d;
    logic [4:0]  count_q, count_d;
    logic [4:0]  dest_q, dest_d;
    logic [31:0] result_q, result_d;
    logic        c_q, c_d;
    logic        v_q, v_d;
    logic        trap_q, trap_d;
    logic        illegal_q, illegal_d;

    decode_t     dec;
    logic [31:0] imm_ext;
    logic [31:0] issue_t;
    logic [4:0]  issue_count;
    logic        trap_now;

    alu_issue_decode u_decode (
        .instr (instr),
        .dec   (dec)
    );

    assign imm_ext     = (dec.imm_mode == IMM_SEXT) ? {{16{instr[15]}}, instr[15:0]}
                                                    : {16'h0000, instr[15:0]};
    assign issue_t     = (dec.imm_mode == IMM_NONE) ? rt_val : imm_ext;
    assign issue_count = dec.var_shift ? rs_val[4:0] : dec.shamt;
    assign trap_now    = (TRAP_ON_OVF != 0) && ovf_can_trap(fsel_q) && V;

    // in_ready stays low while reset is held and rises on the first edge after release
    assign in_ready  = (state_q == ST_IDLE) && armed_q;
    assign out_valid = (state_q == ST_DONE);
    assign F_Sel     = fsel_q;
    assign S         = s_q;
    assign T         = t_q;
    assign result    = result_q;
    assign c_flag    = c_q;
    assign v_flag    = v_q;
    assign dest      = dest_q;
    assign ovf_trap  = trap_q;
    assign illegal   = illegal_q;

    // State, operand, counter and capture registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            armed_q   <= 1'b0;
            fsel_q    <= FS_PASS_S;
            s_q       <= '0;
            t_q       <= '0;
            count_q   <= '0;
            dest_q    <= '0;
            result_q  <= '0;
            c_q       <= 1'b0;
            v_q       <= 1'b0;
            trap_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            armed_q   <= 1'b1;
            fsel_q    <= fsel_d;
            s_q       <= s_d;
            t_q       <= t_d;
            count_q   <= count_d;
            dest_q    <= dest_d;
            result_q  <= result_d;
            c_q       <= c_d;
            v_q       <= v_d;
            trap_q    <= trap_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic: issue in IDLE, iterate/capture in EXEC, hold until handshake in DONE
    always_comb begin
        state_d   = state_q;
        fsel_d    = fsel_q;
        s_d       = s_q;
        t_d       = t_q;
        count_d   = count_q;
        dest_d    = dest_q;
        result_d  = result_q;
        c_d       = c_q;
        v_d       = v_q;
        trap_d    = trap_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    trap_d = 1'b0;
                    if (dec.illegal) begin
                        // Nothing to execute: report straight away with a zeroed result
                        state_d   = ST_DONE;
                        illegal_d = 1'b1;
                        result_d  = '0;
                        dest_d    = '0;
                        c_d       = 1'b0;
                        v_d       = 1'b0;
                    end else begin
                        state_d   = ST_EXEC;
                        illegal_d = 1'b0;
                        // A zero-length shift just passes T through in one cycle
                        fsel_d    = (dec.is_shift && issue_count == 5'd0) ? FS_PASS_T : dec.fsel;
                        s_d       = rs_val;
                        t_d       = issue_t;
                        count_d   = issue_count;
                        dest_d    = dec.dest;
                    end
                end
            end
            ST_EXEC: begin
                // Each shift step feeds the ALU output back as the next T
                if (count_q != 5'd0) begin
                    t_d     = Y;
                    count_d = count_q - 5'd1;
                end
                if (count_q <= 5'd1) begin
                    state_d  = ST_DONE;
                    result_d = Y;
                    c_d      = C && flags_defined(fsel_q);
                    v_d      = V && flags_defined(fsel_q);
                    trap_d   = trap_now;
                    if (trap_now) begin
                        dest_d = '0;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d   = ST_IDLE;
                    trap_d    = 1'b0;
                    illegal_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
